// File: rtl/bp_mem_cmd_mux.sv
// N-channel memory command multiplexer: round-robin command arbitration, an in-order
// tracker of issuing channels, and steering of each memory response back to its issuer.
module bp_mem_cmd_mux #(
  parameter int num_ch_p          = 2,
  parameter int cmd_width_p       = 128,
  parameter int resp_width_p      = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_ch_p*cmd_width_p-1:0]       cmd_i,
  input  logic [num_ch_p-1:0]                   cmd_v_i,
  output logic [num_ch_p-1:0]                   cmd_ready_o,
  output logic [num_ch_p*resp_width_p-1:0]      resp_o,
  output logic [num_ch_p-1:0]                   resp_v_o,
  input  logic [num_ch_p-1:0]                   resp_yumi_i,
  output logic [cmd_width_p-1:0]                mem_cmd_o,
  output logic                                  mem_cmd_v_o,
  input  logic                                  mem_cmd_ready_i,
  input  logic [resp_width_p-1:0]               mem_resp_i,
  input  logic                                  mem_resp_v_i,
  output logic                                  mem_resp_yumi_o,
  output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
  output logic                                  error_o
);

  localparam int ch_w_lp  = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  logic [ch_w_lp-1:0]     rr_ptr_reg;
  logic [ch_w_lp-1:0]     grant;
  logic                   any_v;
  logic [cmd_width_p-1:0] cmd_arr [num_ch_p];
  logic [ch_w_lp-1:0]     tracker_mem [max_outstanding_p];
  logic [ptr_w_lp-1:0]    wr_ptr_reg;
  logic [ptr_w_lp-1:0]    rd_ptr_reg;
  logic [cnt_w_lp-1:0]    count_reg;
  logic                   error_reg;
  logic                   full;
  logic                   empty;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [ch_w_lp-1:0]     head;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Scan from the farthest offset back to rr_ptr so the nearest requester wins.
  always_comb begin
    int idx_i;
    idx_i = 0;
    grant = rr_ptr_reg;
    any_v = 1'b0;
    for (int off = num_ch_p - 1; off >= 0; off--) begin
      idx_i = (int'(rr_ptr_reg) + off) % num_ch_p;
      if (cmd_v_i[ch_w_lp'(idx_i)]) begin
        grant = ch_w_lp'(idx_i);
        any_v = 1'b1;
      end
    end
  end

  assign full  = (count_reg == cnt_w_lp'(max_outstanding_p));
  assign empty = (count_reg == '0);
  assign head  = tracker_mem[rd_ptr_reg];

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  assign issue = reset_n_i & any_v & ~full;
  assign push  = issue & mem_cmd_ready_i;
  assign pop   = reset_n_i & ~empty & mem_resp_v_i & resp_yumi_i[head];

  assign mem_cmd_v_o     = issue;
  assign mem_cmd_o       = cmd_arr[grant];
  assign mem_resp_yumi_o = pop;
  assign outstanding_o   = count_reg;
  assign error_o         = error_reg;

  generate
    for (genvar gi = 0; gi < num_ch_p; gi++) begin : g_ch
      assign cmd_arr[gi] = cmd_i[gi*cmd_width_p +: cmd_width_p];
      assign cmd_ready_o[gi] = push & (grant == ch_w_lp'(gi));
      assign resp_o[gi*resp_width_p +: resp_width_p] = mem_resp_i;
      assign resp_v_o[gi] = reset_n_i & mem_resp_v_i & ~empty & (head == ch_w_lp'(gi));
    end
  endgenerate

  // Tracker storage carries no reset; validity is defined by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tracker_mem[wr_ptr_reg] <= grant;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      error_reg  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr_reg <= (grant == ch_w_lp'(num_ch_p - 1)) ? '0 : grant + ch_w_lp'(1);
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + cnt_w_lp'(1);
        2'b01:   count_reg <= count_reg - cnt_w_lp'(1);
        default: count_reg <= count_reg;
      endcase
      if (mem_resp_v_i && empty) begin
        error_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bp_mem_cmd_mux.sv
// Directed bench for bp_mem_cmd_mux: a vector table for arbitration/tracking plus
// hand-written sequences for mid-cycle reset, orphan responses and round-robin fairness.
module tb_bp_mem_cmd_mux;

  logic         clk_i;
  logic         reset_n_i;
  logic [255:0] cmd_i;
  logic [1:0]   cmd_v_i;
  logic [1:0]   cmd_ready_o;
  logic [255:0] resp_o;
  logic [1:0]   resp_v_o;
  logic [1:0]   resp_yumi_i;
  logic [127:0] mem_cmd_o;
  logic         mem_cmd_v_o;
  logic         mem_cmd_ready_i;
  logic [127:0] mem_resp_i;
  logic         mem_resp_v_i;
  logic         mem_resp_yumi_o;
  logic [2:0]   outstanding_o;
  logic         error_o;

  bp_mem_cmd_mux #(
    .num_ch_p(2), .cmd_width_p(128), .resp_width_p(128), .max_outstanding_p(4)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_i(cmd_i), .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .resp_o(resp_o), .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] cv;
    logic       mr;
    logic       rv;
    logic [1:0] ry;
    logic [1:0] e_crdy;
    logic       e_mcv;
    logic       e_g;
    logic [1:0] e_rv;
    logic       e_yumi;
    logic [2:0] e_out;
    logic       e_err;
  } vec_t;

  vec_t vecs [20];
  int checks;
  int errors;
  logic [127:0] cmd_ch0;
  logic [127:0] cmd_ch1;
  int grants [2];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] cv, input logic mr, input logic rv,
                              input logic [1:0] ry, input logic [1:0] e_crdy,
                              input logic e_mcv, input logic e_g, input logic [1:0] e_rv,
                              input logic e_yumi, input logic [2:0] e_out, input logic e_err);
    vec_t v;
    v.cv = cv; v.mr = mr; v.rv = rv; v.ry = ry;
    v.e_crdy = e_crdy; v.e_mcv = e_mcv; v.e_g = e_g; v.e_rv = e_rv;
    v.e_yumi = e_yumi; v.e_out = e_out; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    grants[0] = 0;
    grants[1] = 0;
    cmd_ch0 = 128'h1111_0000_0000_00C0;
    cmd_ch1 = 128'h2222_0000_0000_00C1;
    cmd_i = {cmd_ch1, cmd_ch0};
    mem_resp_i = 128'hBEEF_0000_0000_0000_0000_0000_0000_CAFE;

    //                 cv    mr    rv    ry     crdy  mcv   g     rv     yumi  out   err
    vecs[0]  = mk(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0);
    vecs[1]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0);
    vecs[2]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 3'd1, 1'b0);
    vecs[3]  = mk(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 3'd2, 1'b0);
    vecs[4]  = mk(2'b10, 1'b1, 1'b1, 2'b00, 2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 3'd2, 1'b0);
    vecs[5]  = mk(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 3'd3, 1'b0);
    vecs[6]  = mk(2'b01, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 2'b10, 1'b0, 3'd2, 1'b0);
    vecs[7]  = mk(2'b01, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 3'd3, 1'b0);
    vecs[8]  = mk(2'b10, 1'b1, 1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 3'd3, 1'b0);
    vecs[9]  = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd4, 1'b0);
    vecs[10] = mk(2'b11, 1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 3'd4, 1'b0);
    vecs[11] = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 3'd3, 1'b0);
    vecs[12] = mk(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 3'd4, 1'b0);
    vecs[13] = mk(2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 3'd3, 1'b0);
    vecs[14] = mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 3'd2, 1'b0);
    vecs[15] = mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 3'd1, 1'b0);
    vecs[16] = mk(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0);
    vecs[17] = mk(2'b00, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0);
    vecs[18] = mk(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1);
    vecs[19] = mk(2'b11, 1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 3'd0, 1'b1);

    // Reset held with every request asserted: all handshakes must stay quiet.
    reset_n_i = 1'b0;
    cmd_v_i = 2'b11;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i = 1'b1;
    resp_yumi_i = 2'b11;
    @(negedge clk_i);
    #1;
    chk("rst_cmd_ready", 256'(cmd_ready_o), 256'(2'b00));
    chk("rst_mem_cmd_v", 256'(mem_cmd_v_o), 256'(1'b0));
    chk("rst_resp_v", 256'(resp_v_o), 256'(2'b00));
    chk("rst_mem_yumi", 256'(mem_resp_yumi_o), 256'(1'b0));
    chk("rst_outstanding", 256'(outstanding_o), 256'(3'd0));
    chk("rst_error", 256'(error_o), 256'(1'b0));
    @(negedge clk_i);
    reset_n_i = 1'b1;
    cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b0;
    resp_yumi_i = 2'b00;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      cmd_v_i = vecs[i].cv;
      mem_cmd_ready_i = vecs[i].mr;
      mem_resp_v_i = vecs[i].rv;
      resp_yumi_i = vecs[i].ry;
      #1;
      $display("vec %0d: cv=%b mr=%b rv=%b ry=%b -> crdy=%b mcv=%b rvo=%b yumi=%b out=%0d err=%b",
               i, cmd_v_i, mem_cmd_ready_i, mem_resp_v_i, resp_yumi_i, cmd_ready_o,
               mem_cmd_v_o, resp_v_o, mem_resp_yumi_o, outstanding_o, error_o);
      chk($sformatf("v%0d_cmd_ready", i), 256'(cmd_ready_o), 256'(vecs[i].e_crdy));
      chk($sformatf("v%0d_mem_cmd_v", i), 256'(mem_cmd_v_o), 256'(vecs[i].e_mcv));
      if (vecs[i].e_mcv)
        chk($sformatf("v%0d_mem_cmd", i), 256'(mem_cmd_o),
            256'(vecs[i].e_g ? cmd_ch1 : cmd_ch0));
      chk($sformatf("v%0d_resp_v", i), 256'(resp_v_o), 256'(vecs[i].e_rv));
      chk($sformatf("v%0d_mem_yumi", i), 256'(mem_resp_yumi_o), 256'(vecs[i].e_yumi));
      chk($sformatf("v%0d_outstanding", i), 256'(outstanding_o), 256'(vecs[i].e_out));
      chk($sformatf("v%0d_error", i), 256'(error_o), 256'(vecs[i].e_err));
      if (i == 4)
        chk("resp_broadcast", resp_o, {mem_resp_i, mem_resp_i});
    end

    // Bring the tracker to 2 outstanding, then drop reset between clock edges.
    @(negedge clk_i);
    cmd_v_i = 2'b01;
    mem_cmd_ready_i = 1'b1;
    mem_resp_v_i = 1'b0;
    resp_yumi_i = 2'b00;
    @(negedge clk_i);
    cmd_v_i = 2'b11;
    mem_resp_v_i = 1'b1;
    resp_yumi_i = 2'b11;
    #1;
    chk("pre_rst_outstanding", 256'(outstanding_o), 256'(3'd2));
    #1;
    reset_n_i = 1'b0;
    #1;
    $display("async reset: crdy=%b mcv=%b rvo=%b yumi=%b out=%0d err=%b",
             cmd_ready_o, mem_cmd_v_o, resp_v_o, mem_resp_yumi_o, outstanding_o, error_o);
    chk("arst_cmd_ready", 256'(cmd_ready_o), 256'(2'b00));
    chk("arst_mem_cmd_v", 256'(mem_cmd_v_o), 256'(1'b0));
    chk("arst_resp_v", 256'(resp_v_o), 256'(2'b00));
    chk("arst_mem_yumi", 256'(mem_resp_yumi_o), 256'(1'b0));
    chk("arst_outstanding", 256'(outstanding_o), 256'(3'd0));
    chk("arst_error", 256'(error_o), 256'(1'b0));

    // Release with a stale response pending: it is an orphan and must raise error_o.
    @(negedge clk_i);
    reset_n_i = 1'b1;
    cmd_v_i = 2'b00;
    #1;
    $display("orphan: rvo=%b yumi=%b err=%b", resp_v_o, mem_resp_yumi_o, error_o);
    chk("orphan_resp_v", 256'(resp_v_o), 256'(2'b00));
    chk("orphan_mem_yumi", 256'(mem_resp_yumi_o), 256'(1'b0));
    chk("orphan_error_pre", 256'(error_o), 256'(1'b0));
    @(negedge clk_i);
    mem_resp_v_i = 1'b0;
    resp_yumi_i = 2'b00;
    cmd_v_i = 2'b11;
    #1;
    $display("post reset grant: crdy=%b err=%b", cmd_ready_o, error_o);
    chk("orphan_error_set", 256'(error_o), 256'(1'b1));
    chk("post_rst_grant", 256'(cmd_ready_o), 256'(2'b01));
    chk("post_rst_mem_cmd", 256'(mem_cmd_o), 256'(cmd_ch0));

    // Fairness: both channels request every cycle, each response consumed next cycle.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      cmd_v_i = 2'b11;
      mem_resp_v_i = 1'b1;
      resp_yumi_i = 2'b11;
      #1;
      $display("rr %0d: crdy=%b out=%0d", c, cmd_ready_o, outstanding_o);
      chk($sformatf("rr%0d_grant", c), 256'(cmd_ready_o),
          256'((c % 2 == 0) ? 2'b10 : 2'b01));
      if (cmd_ready_o == 2'b01) grants[0]++;
      if (cmd_ready_o == 2'b10) grants[1]++;
    end
    @(negedge clk_i);
    cmd_v_i = 2'b00;
    mem_resp_v_i = 1'b0;
    resp_yumi_i = 2'b00;
    #1;
    chk("rr_grants_ch0", 256'(grants[0]), 256'(50));
    chk("rr_grants_ch1", 256'(grants[1]), 256'(50));
    chk("rr_outstanding", 256'(outstanding_o), 256'(3'd1));
    chk("error_sticky", 256'(error_o), 256'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
